if_mem_ctrl: RTL and testbench

- Byte-serial memory controller sitting directly upstream of the instruction-fetch stage.
- Serves instruction-word fetches from IF and load/store accesses from MEM over a single 8-bit synchronous RAM port.
- Assembles little-endian words and returns them with a one-cycle done pulse.
- Arbitrates between the two requesters and supports abort of an in-flight fetch on branch redirect.

---
 rtl/if_mem_ctrl_if.sv | 38 +++
 rtl/if_mem_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_if_mem_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// if_mem_ctrl_if : request/response and byte-RAM bundle of the IF/MEM
//                  memory controller.
// Revision 1.0 - initial release
// ============================================================================
interface if_mem_ctrl_if #(
  parameter int MEM_AW = 17
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_ok;
  logic [31:0]       if_data;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [1:0]        d_width;
  logic [31:0]       d_wdata;
  logic              d_ok;
  logic [31:0]       d_rdata;
  logic [MEM_AW-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_width, d_wdata, mem_din,
    output if_ok, if_data, d_ok, d_rdata, mem_a, mem_wr, mem_dout, busy
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_width, d_wdata, mem_din,
    input  if_ok, if_data, d_ok, d_rdata, mem_a, mem_wr, mem_dout, busy
  );
endinterface
`default_nettype wire

// File: rtl/if_mem_ctrl.sv
`default_nettype none
// ============================================================================
// if_mem_ctrl : byte-serial controller serving IF fetches and MEM loads/stores
//               over one 8-bit RAM port. Optional fetch buffer: MEMCTL_IBUF_EN.
// Revision 1.0 - initial release
// ============================================================================
module if_mem_ctrl #(
  parameter int MEM_AW = 17
) (
  input  wire logic     clk,
  input  wire logic     rst,
  if_mem_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [MEM_AW-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              if_ok_q, if_ok_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              d_ok_q, d_ok_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic [1:0]        byte_sel;
  logic [2:0]        d_len;
`ifdef MEMCTL_IBUF_EN
  logic              ib_valid_q, ib_valid_d;
  logic [MEM_AW-3:0] ib_tag_q, ib_tag_d;
  logic [31:0]       ib_word_q, ib_word_d;
  logic              hit_q, hit_d;
  logic [MEM_AW-1:0] st_a;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.if_addr[31:MEM_AW], bus.d_addr[31:MEM_AW]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = 1'b0;
    mem_dout_d = mem_dout_q;
    if_ok_d    = 1'b0;
    if_data_d  = if_data_q;
    d_ok_d     = 1'b0;
    d_rdata_d  = d_rdata_q;
    byte_sel   = 2'(cnt_q - 3'd1);
    d_len      = (bus.d_width == 2'd0) ? 3'd1 : (bus.d_width == 2'd1) ? 3'd2 : 3'd4;
`ifdef MEMCTL_IBUF_EN
    ib_valid_d = ib_valid_q;
    ib_tag_d   = ib_tag_q;
    ib_word_d  = ib_word_q;
    hit_d      = 1'b0;
    st_a       = '0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          state_d = DACC;
          cnt_d   = 3'd0;
          len_d   = d_len;
          we_d    = bus.d_we;
          mem_a_d = bus.d_addr[MEM_AW-1:0];
          buf_d   = '0;
          if (bus.d_we) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.d_wdata[7:0];
            wdata_d    = bus.d_wdata >> 8;
`ifdef MEMCTL_IBUF_EN
            // A store spanning a word boundary may touch the tagged word with any byte
            for (int k = 0; k < 4; k++) begin
              st_a = bus.d_addr[MEM_AW-1:0] + MEM_AW'(k);
              if (3'(k) < d_len && st_a[MEM_AW-1:2] == ib_tag_q)
                ib_valid_d = 1'b0;
            end
`endif
          end
`ifdef MEMCTL_IBUF_EN
        end else if (bus.if_req && !bus.if_flush && ib_valid_q &&
                     ib_tag_q == bus.if_addr[MEM_AW-1:2]) begin
          state_d = IFETCH;
          hit_d   = 1'b1;
`endif
        end else if (bus.if_req && !bus.if_flush) begin
          state_d = IFETCH;
          cnt_d   = 3'd0;
          len_d   = 3'd4;
          we_d    = 1'b0;
          mem_a_d = bus.if_addr[MEM_AW-1:0];
          buf_d   = '0;
        end
      end

      IFETCH, DACC: begin
        if (state_q == IFETCH && bus.if_flush) begin
          state_d = IDLE;
`ifdef MEMCTL_IBUF_EN
        end else if (hit_q) begin
          state_d   = DONE;
          if_ok_d   = 1'b1;
          if_data_d = ib_word_q;
`endif
        end else if (we_q) begin
          if (cnt_q + 3'd1 < len_q) begin
            cnt_d      = cnt_q + 3'd1;
            mem_wr_d   = 1'b1;
            mem_a_d    = mem_a_q + 1'b1;
            mem_dout_d = wdata_q[7:0];
            wdata_d    = wdata_q >> 8;
          end else begin
            state_d = DONE;
            d_ok_d  = 1'b1;
          end
        end else begin
          // Addresses run ahead of captured bytes by the one-cycle RAM latency
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 < len_q)
            mem_a_d = mem_a_q + 1'b1;
          if (cnt_q != 3'd0)
            buf_d[{byte_sel, 3'b000} +: 8] = bus.mem_din;
          if (cnt_q == len_q) begin
            state_d = DONE;
            if (state_q == IFETCH) begin
              if_ok_d   = 1'b1;
              if_data_d = buf_d;
`ifdef MEMCTL_IBUF_EN
              ib_valid_d = 1'b1;
              ib_tag_d   = mem_a_q[MEM_AW-1:2];
              ib_word_d  = buf_d;
`endif
            end else begin
              d_ok_d    = 1'b1;
              d_rdata_d = buf_d;
            end
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      if_ok_q    <= 1'b0;
      if_data_q  <= '0;
      d_ok_q     <= 1'b0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
`ifdef MEMCTL_IBUF_EN
      ib_valid_q <= 1'b0;
      ib_tag_q   <= '0;
      ib_word_q  <= '0;
      hit_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      if_ok_q    <= if_ok_d;
      if_data_q  <= if_data_d;
      d_ok_q     <= d_ok_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
`ifdef MEMCTL_IBUF_EN
      ib_valid_q <= ib_valid_d;
      ib_tag_q   <= ib_tag_d;
      ib_word_q  <= ib_word_d;
      hit_q      <= hit_d;
`endif
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.if_ok    = if_ok_q;
  assign bus.if_data  = if_data_q;
  assign bus.d_ok     = d_ok_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.busy     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_if_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_if_mem_ctrl : directed self-checking bench for if_mem_ctrl with a
//                  behavioural byte RAM (one-cycle read latency).
// Revision 1.0 - initial release
// ============================================================================
module tb_if_mem_ctrl;
  localparam int C_AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] ram [0:(1<<C_AW)-1];

  if_mem_ctrl_if #(.MEM_AW(C_AW)) bus ();

  if_mem_ctrl #(.MEM_AW(C_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until the selected ok pulse, or -1 on timeout
  task automatic wait_ok(input bit sel_d, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if ((sel_d ? bus.d_ok : bus.if_ok) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.if_ok !== 1'b0 || bus.d_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got=%b%b exp=00", bus.if_ok, bus.d_ok); end
    checks++; if (bus.if_data !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", bus.if_data, bus.d_rdata); end
    checks++; if (bus.mem_a !== 17'h0 || bus.mem_wr !== 1'b0 || bus.mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem got=%h/%b/%h exp=0/0/0", bus.mem_a, bus.mem_wr, bus.mem_dout); end
    rst = 1'b0;
    tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_fetch;
    logic [16:0] exp_a;
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      exp_a = (k <= 3) ? 17'(16 + k) : 17'h13;
      checks++; if (bus.mem_a !== exp_a || bus.mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_mem_a k=%0d got=%h wr=%b exp=%h wr=0", k, bus.mem_a, bus.mem_wr, exp_a); end
      checks++; if (bus.if_ok !== (k == 5)) begin errors++; $display("FAIL fetch_if_ok k=%0d got=%b exp=%b", k, bus.if_ok, (k == 5)); end
    end
    checks++; if (bus.if_data !== 32'hDF9B5713) begin errors++; $display("FAIL fetch_data got=%h exp=DF9B5713", bus.if_data); end
    bus.if_req = 1'b0;
    tick;
    checks++; if (bus.if_ok !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL fetch_after_done got ok=%b busy=%b exp=0/0", bus.if_ok, bus.busy); end
  endtask

  task automatic test_store;
    logic [16:0] exp_a [3];
    logic [7:0]  exp_d [3];
    exp_a = '{17'h20, 17'h21, 17'h21};
    exp_d = '{8'hDD, 8'hCC, 8'hCC};
    bus.d_addr  = 32'h20;
    bus.d_we    = 1'b1;
    bus.d_width = 2'd1;
    bus.d_wdata = 32'hAABBCCDD;
    bus.d_req   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (bus.mem_wr !== (k < 2) || bus.mem_a !== exp_a[k] || (k < 2 && bus.mem_dout !== exp_d[k])) begin
        errors++; $display("FAIL store_bus k=%0d got wr=%b a=%h d=%h exp wr=%b a=%h d=%h", k, bus.mem_wr, bus.mem_a, bus.mem_dout, (k < 2), exp_a[k], exp_d[k]); end
      checks++; if (bus.d_ok !== (k == 2)) begin errors++; $display("FAIL store_d_ok k=%0d got=%b exp=%b", k, bus.d_ok, (k == 2)); end
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick;
    checks++; if (bus.d_ok !== 1'b0) begin errors++; $display("FAIL store_ok_pulse got=%b exp=0", bus.d_ok); end
    checks++; if (ram[32'h20] !== 8'hDD || ram[32'h21] !== 8'hCC || ram[32'h22] !== 8'h00) begin
      errors++; $display("FAIL store_ram got=%h %h %h exp=DD CC 00", ram[32'h20], ram[32'h21], ram[32'h22]); end
  endtask

  task automatic test_arb;
    int n;
    bus.d_addr  = 32'h20;
    bus.d_we    = 1'b0;
    bus.d_width = 2'd0;
    bus.d_req   = 1'b1;
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    wait_ok(1'b1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL arb_load_latency got=%0d exp=3", n); end
    checks++; if (bus.d_rdata !== 32'h000000DD) begin errors++; $display("FAIL arb_load_data got=%h exp=000000DD", bus.d_rdata); end
    checks++; if (bus.if_ok !== 1'b0) begin errors++; $display("FAIL arb_if_ok_early got=%b exp=0", bus.if_ok); end
    bus.d_req = 1'b0;
    wait_ok(1'b0, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL arb_fetch_latency got=%0d exp=7", n); end
    checks++; if (bus.if_data !== 32'hDF9B5713 || bus.d_rdata !== 32'h000000DD) begin
      errors++; $display("FAIL arb_fetch_data got=%h/%h exp=DF9B5713/000000DD", bus.if_data, bus.d_rdata); end
    bus.if_req = 1'b0;
    tick;
  endtask

  task automatic test_flush;
    int n;
    int seen;
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    repeat (3) tick;
    bus.if_flush = 1'b1;
    bus.if_req   = 1'b0;
    tick;
    bus.if_flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.if_ok !== 1'b0) begin errors++; $display("FAIL flush_abort got busy=%b ok=%b exp=0/0", bus.busy, bus.if_ok); end
    seen = 0;
    repeat (6) begin
      tick;
      if (bus.if_ok === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_ok got=%0d pulses exp=0", seen); end
    checks++; if (bus.if_data !== 32'hDF9B5713) begin errors++; $display("FAIL flush_data_hold got=%h exp=DF9B5713", bus.if_data); end
    bus.if_addr = 32'h14;
    bus.if_req  = 1'b1;
    wait_ok(1'b0, n);
    checks++; if (n !== 6 || bus.if_data !== 32'h04030201) begin errors++; $display("FAIL flush_refetch got n=%0d data=%h exp n=6 data=04030201", n, bus.if_data); end
    bus.if_req = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_store;
    bus.d_addr  = 32'h30;
    bus.d_we    = 1'b1;
    bus.d_width = 2'd2;
    bus.d_wdata = 32'h11223344;
    bus.d_req   = 1'b1;
    tick;
    checks++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h44) begin errors++; $display("FAIL rstmid_first got wr=%b d=%h exp 1/44", bus.mem_wr, bus.mem_dout); end
    rst = 1'b1;
    tick;
    checks++; if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.d_ok !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort got wr=%b busy=%b ok=%b exp 0/0/0", bus.mem_wr, bus.busy, bus.d_ok); end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    checks++; if (ram[32'h30] !== 8'h44 || ram[32'h31] !== 8'h00 || bus.d_ok !== 1'b0) begin
      errors++; $display("FAIL rstmid_ram got=%h %h ok=%b exp=44 00 ok=0", ram[32'h30], ram[32'h31], bus.d_ok); end
    checks++; if (bus.if_data !== 32'h0) begin errors++; $display("FAIL rstmid_if_data got=%h exp=0", bus.if_data); end
  endtask

  task automatic test_ibuf;
    int n;
    int exp_n;
`ifdef MEMCTL_IBUF_EN
    exp_n = 2;
`else
    exp_n = 6;
`endif
    bus.if_addr = 32'h10;
    bus.if_req  = 1'b1;
    wait_ok(1'b0, n);
    checks++; if (n !== 6 || bus.if_data !== 32'hDF9B5713) begin errors++; $display("FAIL ibuf_fill got n=%0d data=%h exp 6/DF9B5713", n, bus.if_data); end
    bus.if_req = 1'b0;
    tick;
    bus.if_req = 1'b1;
    wait_ok(1'b0, n);
    checks++; if (n !== exp_n || bus.if_data !== 32'hDF9B5713) begin errors++; $display("FAIL ibuf_second got n=%0d data=%h exp %0d/DF9B5713", n, bus.if_data, exp_n); end
    checks++; if (bus.mem_a !== 17'h13) begin errors++; $display("FAIL ibuf_mem_a got=%h exp=13", bus.mem_a); end
    bus.if_req = 1'b0;
    tick;
    bus.d_addr  = 32'h12;
    bus.d_we    = 1'b1;
    bus.d_width = 2'd0;
    bus.d_wdata = 32'h0000005A;
    bus.d_req   = 1'b1;
    wait_ok(1'b1, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL ibuf_store_latency got=%0d exp=2", n); end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick;
    bus.if_req = 1'b1;
    wait_ok(1'b0, n);
    checks++; if (n !== 6 || bus.if_data !== 32'hDF5A5713) begin errors++; $display("FAIL ibuf_invalidate got n=%0d data=%h exp 6/DF5A5713", n, bus.if_data); end
    bus.if_req = 1'b0;
    tick;
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_width  = '0;
    bus.d_wdata  = '0;
    for (int i = 0; i < (1 << C_AW); i++) ram[i] = 8'h00;
    ram[32'h10] = 8'h13; ram[32'h11] = 8'h57; ram[32'h12] = 8'h9B; ram[32'h13] = 8'hDF;
    ram[32'h14] = 8'h01; ram[32'h15] = 8'h02; ram[32'h16] = 8'h03; ram[32'h17] = 8'h04;

    test_reset;
    test_fetch;
    test_store;
    test_arb;
    test_flush;
    test_reset_mid_store;
    test_ibuf;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
